pipe_hazard_ctrl: RTL and testbench

- Central pipeline-control unit for the 5-stage redirect pipeline.
- Generates the load-enable and synchronous-clear controls for the PC, IF/ID and ID/EX pipeline registers from three event sources: load-use hazards, EX-stage branch redirects, and halt/resume.
- Sequences a multi-cycle flush after a redirect.
- Keeps 32-bit stall and flush event counters for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/sat_counter.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/redirect controller:
// state encoding, default register width and the hard-wired zero register.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } ctrl_state_e;

  localparam int DEF_REG_W = 5;
  localparam logic [DEF_REG_W-1:0] ZERO_REG = '0;

  // Flush countdown never needs more than FLUSH_CYCLES-1 <= 2.
  localparam int REM_W = 2;

endpackage

// File: rtl/sat_counter.sv
// Event counter that increments on inc and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: load-use stalls, EX redirect flushes and halt/resume,
// driving PC / IF/ID / ID/EX enables and clears with zero-cycle latency.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W        = DEF_REG_W,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_rd,
  input  logic             id_rt_rd,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [REM_W-1:0] REM_RELOAD = REM_W'(FLUSH_CYCLES - 1);

  ctrl_state_e      state, state_nxt;
  logic [REM_W-1:0] remaining, remaining_nxt;
  logic             lu;
  logic             stall_inc;
  logic             flush_inc;

  // A load into r0 can never create a true dependency.
  assign lu = ex_memread && (ex_rd != REG_W'(ZERO_REG)) &&
              ((id_rs_rd && (id_rs == ex_rd)) || (id_rt_rd && (id_rt == ex_rd)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    case (state)
      ST_RUN: begin
        if (ex_redirect) begin
          if (FLUSH_CYCLES > 1) begin
            state_nxt     = ST_FLUSH;
            remaining_nxt = REM_RELOAD;
          end
        end else if (halt_req) begin
          state_nxt = ST_HALT;
        end
      end
      ST_FLUSH: begin
        if (ex_redirect) begin
          remaining_nxt = REM_RELOAD;
        end else begin
          remaining_nxt = remaining - REM_W'(1);
          if (remaining <= REM_W'(1)) begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt     = ST_RUN;
        remaining_nxt = '0;
      end
    endcase
  end

  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    halted    = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state)
      ST_RUN: begin
        if (ex_redirect) begin
          ifid_clr  = 1'b1;
          idex_clr  = 1'b1;
          flush_inc = 1'b1;
        end else if (halt_req) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_clr = 1'b1;
        end else if (lu) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_clr  = 1'b1;
          stall_inc = 1'b1;
        end
      end
      // Wrong-path instructions are being squashed, so hazards and halts here are moot.
      ST_FLUSH: begin
        ifid_clr  = 1'b1;
        idex_clr  = 1'b1;
        flush_inc = ex_redirect;
      end
      ST_HALT: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_clr = 1'b1;
        halted   = 1'b1;
      end
      default: begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances cover FLUSH_CYCLES=2,
// FLUSH_CYCLES=3 and a 3-bit counter build; ctl vectors are {pc_en,ifid_en,ifid_clr,idex_clr,halted}.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_rs_rd, id_rt_rd, ex_memread, ex_redirect, halt_req, resume;

  logic        a_pc_en, a_ifid_en, a_ifid_clr, a_idex_clr, a_halted;
  logic [31:0] a_stall, a_flush;
  logic        b_pc_en, b_ifid_en, b_ifid_clr, b_idex_clr, b_halted;
  logic [31:0] b_stall, b_flush;
  logic        c_pc_en, c_ifid_en, c_ifid_clr, c_idex_clr, c_halted;
  logic [2:0]  c_stall, c_flush;

  logic [4:0] a_ctl, b_ctl, c_ctl;
  assign a_ctl = {a_pc_en, a_ifid_en, a_ifid_clr, a_idex_clr, a_halted};
  assign b_ctl = {b_pc_en, b_ifid_en, b_ifid_clr, b_idex_clr, b_halted};
  assign c_ctl = {c_pc_en, c_ifid_en, c_ifid_clr, c_idex_clr, c_halted};

  localparam logic [4:0] CTL_RUN   = 5'b11000;
  localparam logic [4:0] CTL_STALL = 5'b00010;
  localparam logic [4:0] CTL_FLUSH = 5'b11110;
  localparam logic [4:0] CTL_HALT  = 5'b00011;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_rs_rd(id_rs_rd),
    .id_rt_rd(id_rt_rd), .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .halt_req(halt_req), .resume(resume), .pc_en(a_pc_en), .ifid_en(a_ifid_en),
    .ifid_clr(a_ifid_clr), .idex_clr(a_idex_clr), .halted(a_halted),
    .stall_cnt(a_stall), .flush_cnt(a_flush));

  pipe_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(3), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_rs_rd(id_rs_rd),
    .id_rt_rd(id_rt_rd), .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .halt_req(halt_req), .resume(resume), .pc_en(b_pc_en), .ifid_en(b_ifid_en),
    .ifid_clr(b_ifid_clr), .idex_clr(b_idex_clr), .halted(b_halted),
    .stall_cnt(b_stall), .flush_cnt(b_flush));

  pipe_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(1), .CNT_W(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_rs_rd(id_rs_rd),
    .id_rt_rd(id_rt_rd), .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .halt_req(halt_req), .resume(resume), .pc_en(c_pc_en), .ifid_en(c_ifid_en),
    .ifid_clr(c_ifid_clr), .idex_clr(c_idex_clr), .halted(c_halted),
    .stall_cnt(c_stall), .flush_cnt(c_flush));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_rs_rd = 1'b0; id_rt_rd = 1'b0; ex_memread = 1'b0;
    ex_redirect = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_load_use_rs(input logic [4:0] r);
    ex_memread = 1'b1; ex_rd = r; id_rs = r; id_rs_rd = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    tick();
    do_reset();

    // ---- Instance A: FLUSH_CYCLES=2 ----
    check("reset_ctl", 32'(a_ctl), 32'(CTL_RUN));
    check("reset_stall", a_stall, 32'd0);
    check("reset_flush", a_flush, 32'd0);

    set_load_use_rs(5'd5); #1;
    check("lu_rs_ctl", 32'(a_ctl), 32'(CTL_STALL));
    tick(); idle_inputs(); #1;
    check("lu_rs_cnt", a_stall, 32'd1);
    check("lu_after_ctl", 32'(a_ctl), 32'(CTL_RUN));

    set_load_use_rs(5'd0); #1;
    check("lu_r0_ctl", 32'(a_ctl), 32'(CTL_RUN));
    tick(); idle_inputs(); #1;
    check("lu_r0_cnt", a_stall, 32'd1);

    ex_memread = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_rt_rd = 1'b1; id_rs = 5'd7; #1;
    check("lu_rt_ctl", 32'(a_ctl), 32'(CTL_STALL));
    tick(); id_rt_rd = 1'b0; #1;
    check("lu_rt_noread_ctl", 32'(a_ctl), 32'(CTL_RUN));
    tick(); idle_inputs(); #1;
    check("lu_rt_cnt", a_stall, 32'd2);

    set_load_use_rs(5'd5); ex_redirect = 1'b1; #1;
    check("redir_c1_ctl", 32'(a_ctl), 32'(CTL_FLUSH));
    tick(); ex_redirect = 1'b0; #1;
    check("redir_c2_ctl", 32'(a_ctl), 32'(CTL_FLUSH));
    tick(); idle_inputs(); #1;
    check("redir_end_ctl", 32'(a_ctl), 32'(CTL_RUN));
    check("redir_flush_cnt", a_flush, 32'd1);
    check("redir_stall_cnt", a_stall, 32'd2);

    halt_req = 1'b1; #1;
    check("halt_req_ctl", 32'(a_ctl), 32'(CTL_STALL));
    tick(); halt_req = 1'b0; #1;
    check("halt_ctl", 32'(a_ctl), 32'(CTL_HALT));
    ex_redirect = 1'b1; #1;
    check("halt_redir_ctl", 32'(a_ctl), 32'(CTL_HALT));
    tick(); ex_redirect = 1'b0; #1;
    check("halt_redir_flush_cnt", a_flush, 32'd1);
    check("halt_hold_ctl", 32'(a_ctl), 32'(CTL_HALT));
    resume = 1'b1; #1;
    check("resume_cycle_ctl", 32'(a_ctl), 32'(CTL_HALT));
    tick(); resume = 1'b0; #1;
    check("resumed_ctl", 32'(a_ctl), 32'(CTL_RUN));

    halt_req = 1'b1;
    tick(); halt_req = 1'b0; #1;
    check("rehalt_ctl", 32'(a_ctl), 32'(CTL_HALT));
    rst_n = 1'b0; #2; rst_n = 1'b1; #1;
    check("async_pulse_ctl", 32'(a_ctl), 32'(CTL_HALT));
    check("async_pulse_stall", a_stall, 32'd2);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; #1;
    check("halt_reset_ctl", 32'(a_ctl), 32'(CTL_RUN));
    check("halt_reset_stall", a_stall, 32'd0);
    check("halt_reset_flush", a_flush, 32'd0);

    // ---- Instance B: FLUSH_CYCLES=3, second redirect on flush cycle 2 ----
    do_reset();
    ex_redirect = 1'b1; #1;
    check("b_flush_c1", 32'(b_ctl), 32'(CTL_FLUSH));
    tick(); #1;
    check("b_flush_c2", 32'(b_ctl), 32'(CTL_FLUSH));
    tick(); ex_redirect = 1'b0; halt_req = 1'b1; #1;
    check("b_flush_c3", 32'(b_ctl), 32'(CTL_FLUSH));
    tick(); halt_req = 1'b0; #1;
    check("b_flush_c4", 32'(b_ctl), 32'(CTL_FLUSH));
    tick(); #1;
    check("b_flush_done", 32'(b_ctl), 32'(CTL_RUN));
    check("b_flush_cnt", b_flush, 32'd2);

    // ---- Instance C: FLUSH_CYCLES=1, CNT_W=3 ----
    do_reset();
    ex_redirect = 1'b1; #1;
    check("c_redir_ctl", 32'(c_ctl), 32'(CTL_FLUSH));
    tick(); ex_redirect = 1'b0; #1;
    check("c_redir_after", 32'(c_ctl), 32'(CTL_RUN));
    check("c_flush_cnt", 32'(c_flush), 32'd1);
    set_load_use_rs(5'd9);
    for (int i = 0; i < 10; i++) tick();
    #1;
    check("c_sat_ctl", 32'(c_ctl), 32'(CTL_STALL));
    check("c_stall_sat", 32'(c_stall), 32'd7);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
